// File: rtl/maxnet_loader.sv
// Front-end for maxnet: collects N activations (negatives clamped to +0), launches maxnet,
// then locates the winning slot in the stored vector and returns {index, value} downstream.
module maxnet_loader #(
   parameter int N  = 4,
   parameter int W  = 32,
   parameter int IW = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic [N*W-1:0] mx_x,
   output logic           mx_start,
   input  logic           mx_done,
   input  logic [W-1:0]   mx_result,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic [IW-1:0]  out_index,
   output logic           out_miss
);

   localparam logic [2:0] S_LOAD  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_MATCH = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [2:0]    state;
   logic [IW-1:0] cnt;
   logic [IW-1:0] k;
   logic [IW-1:0] idx;
   logic          found;
   logic [W-1:0]  res;
   logic [W-1:0]  mem [N];

   function automatic logic [W-1:0] clamp_neg(input logic [W-1:0] v);
      return v[W-1] ? '0 : v;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_LOAD;
         cnt   <= '0;
         k     <= '0;
         idx   <= '0;
         found <= 1'b0;
         res   <= '0;
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (in_valid) begin
                  mem[cnt] <= clamp_neg(in_data);
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= S_START;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_START: state <= S_WAIT;
            S_WAIT: begin
               if (mx_done) begin
                  res   <= mx_result;
                  k     <= '0;
                  found <= 1'b0;
                  state <= S_MATCH;
               end
            end
            S_MATCH: begin
               // First bitwise hit wins, so ties resolve to the lowest slot
               if (!found && mem[k] == res) begin
                  idx   <= k;
                  found <= 1'b1;
               end
               if (k == LAST) state <= S_OUT;
               else           k     <= k + 1'b1;
            end
            S_OUT: begin
               if (out_ready) begin
                  cnt   <= '0;
                  state <= S_LOAD;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == S_LOAD) && !rst;
      mx_start  = (state == S_START);
      out_valid = (state == S_OUT);
      out_data  = res;
      out_miss  = (state == S_OUT) && !found;
      out_index = ((state == S_OUT) && !found) ? LAST : idx;
      mx_x      = '0;
      for (int i = 0; i < N; i++) mx_x[i*W +: W] = mem[i];
   end

endmodule

// File: doc/maxnet_loader.md
# maxnet_loader

Front-end stage for `maxnet`. Accepts N IEEE-754 single-precision activations over a valid/ready stream and clamps negatives to +0. Presents the vector to `maxnet` in parallel and pulses its `start`, then waits for `done`. Captures `result`, resolves the winning index by scanning the stored vector, and hands `{index, value}` downstream over a second valid/ready port.

## Interface
- `N`, 4, number of activations per job (≥2)
- `W`, 32, activation width (IEEE-754 single)
- `IW`, 2, index width, ≥ clog2(N)
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous and active-high (one clock; reset is synchronous and active-high)
- `in_valid`  in  1  upstream activation valid
- `in_ready`  out  1  loader can accept an activation
- `in_data`  in  W  activation value
- `mx_x`  out  N*W  activation vector to maxnet; slot k at bits [k*W +: W]
- `mx_start`  out  1  one-cycle start pulse to maxnet
- `mx_done`  in  1  maxnet completion
- `mx_result`  in  W  maxnet winning value, valid when `mx_done`=1
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  W  winning value
- `out_index`  out  IW  lowest slot whose stored value equals `out_data`
- `out_miss`  out  1  no stored slot matched `mx_result`

## Operation
- States: LOAD, START, WAIT, MATCH, OUT.
- **LOAD**
  - `in_ready`=1.
  - On `in_valid&in_ready`, write `in_data` to slot `cnt`, then increment `cnt`.
  - Clamp rule: if `in_data[W-1]`=1, store 32'h0000_0000; otherwise store `in_data` unchanged. NaN/Inf are not special-cased.
  - When the accept fills slot N-1, go to START.
- **START**
  - `mx_start`=1 for exactly this cycle.
  - Next state is WAIT.
- **WAIT**
  - Hold until `mx_done`=1 is sampled.
  - On that edge, capture `mx_result` into `res`, clear `k`=0 and `found`=0, and go to MATCH.
- **MATCH**
  - One slot per cycle.
  - If `!found && buf[k]==res` (bitwise), record `idx`=k and set `found`=1.
  - When k=N-1, go to OUT; otherwise increment k.
- **OUT**
  - `out_valid`=1.
  - `out_data`=`res`.
  - `out_index`=`idx`, or N-1 if `!found`.
  - `out_miss`=`!found`.
  - On `out_ready`, go to LOAD with `cnt`=0 and the buffer retained until overwritten.
- `mx_x` reflects the buffer continuously and is stable from START through OUT, because the buffer is written only in LOAD.
- `mx_done` is ignored outside WAIT.
- `in_valid` is ignored outside LOAD.

## Timing
- **Reset** (`rst` sampled high, any state):
  - State goes to LOAD, `cnt`=0, buffer cleared to 0, `res`=0, `idx`=0, `found`=0.
  - Reset values of all outputs:
    - `mx_start`=0, `mx_x`=0.
    - `out_valid`=0, `out_data`=0, `out_index`=0, `out_miss`=0.
  - `in_ready` is forced to 0 while `rst`=1 and becomes 1 the cycle after release.
  - Reset mid-job abandons the job with no output produced. `maxnet` shares `rst` at the top level.
- **Load phase:** minimum N cycles with `in_valid` held high; each accept takes one cycle.
- **Start pulse:** `mx_start` rises the cycle after the N-th accept and lasts one cycle.
- **Result latency:** with the `mx_done` cycle as cycle 0, MATCH occupies cycles 1..N and `out_valid` asserts in cycle N+1.
- **Output hold:** `out_valid` and the out fields hold stable until the `out_ready` cycle; `out_valid`=0 on the next cycle.
- **Back-to-back jobs:** `in_ready`=1 on the cycle after the out handshake.
- **Simultaneous events:**
  - `mx_done` in the same cycle that START pulses is not accepted, because the state is not yet WAIT.
  - `rst` together with any handshake: reset wins and the handshake is discarded.

## Test plan
- **Basic job:** load 1.0, 2.0, 0.5, 3.0 (3F800000, 40000000, 3F000000, 40400000). Expect:
  - `mx_start` pulses exactly 1 cycle after the 4th accept.
  - Model returns `mx_result`=40400000 → `out_data`=40400000, `out_index`=3, `out_miss`=0, and `out_valid` asserts N+1 cycles after `mx_done`.
- **Clamp:** load C0000000, 3F800000, BF800000, 3F000000. Expect `mx_x` slots to equal 0, 3F800000, 0, 3F000000.
- **Tie and miss:**
  - Load 2.0, 3.0, 3.0, 1.0 with result 40400000 → `out_index`=1.
  - Result 40A00000 (not present) → `out_miss`=1, `out_index`=3.
- **Backpressure:**
  - Hold `out_ready`=0 for 10 cycles → outputs stable and `in_ready`=0 throughout.
  - Gaps in `in_valid` during LOAD → slots filled in acceptance order.
- **Reset mid-operation:** assert `rst` one cycle in WAIT → next cycle all outputs are at reset values and `in_ready`=1. A subsequent full job completes correctly, and a late `mx_done` arriving in LOAD is ignored.
